// File: rtl/pipelined_ripple_adder.sv
// Pipelined N-bit adder/subtractor built from CHUNK-bit ripple slices.
// One slice per pipeline stage; the carry is registered between slices.
// Lower result chunks and upper operand chunks travel in skew registers
// so each transaction stays aligned. Valid/ready on both sides with full
// backpressure and bubble squeezing.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   a, b, cin, sub      operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready output handshake
//   sum, cout, ovf      result, carry out of MSB, signed overflow
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    // Configuration sanity: slices must tile the word exactly.
    if (CHUNK == 0 || WIDTH == 0 || (WIDTH % CHUNK) != 0) begin : g_cfg_check
        $error("pipelined_ripple_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    logic [STAGES-1:0] adv;      // stage k may load this cycle
    logic [STAGES-1:0] stage_v;  // stage valid bits
    logic [WIDTH-1:0]  b_eff;
    logic              c0;

    // Subtract is a + ~b + 1.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned IN_W  = WIDTH - k * CHUNK;   // operand bits still to consume
        localparam int unsigned RES_W = (k + 1) * CHUNK;     // result bits known after this stage

        logic             v_in;
        logic             c_in;
        logic [IN_W-1:0]  a_in;
        logic [IN_W-1:0]  b_in;
        logic [RES_W-1:0] res_d;
        logic [CHUNK:0]   chunk_sum;
        logic             v_q;
        logic             c_q;
        logic [RES_W-1:0] res_q;

        // Unrolled form of "empty, or the next stage advances": a stage is
        // blocked only when it and every stage after it are full and the
        // output is stalled. No combinational chain between bits.
        assign adv[k] = ~(&stage_v[STAGES-1:k]) | out_ready;

        if (k == 0) begin : g_src
            assign v_in  = in_valid;
            assign c_in  = c0;
            assign a_in  = a;
            assign b_in  = b_eff;
            assign res_d = chunk_sum[CHUNK-1:0];
        end else begin : g_src
            assign v_in  = g_stage[k-1].v_q;
            assign c_in  = g_stage[k-1].c_q;
            assign a_in  = g_stage[k-1].g_tail.a_hi_q;
            assign b_in  = g_stage[k-1].g_tail.b_hi_q;
            assign res_d = {chunk_sum[CHUNK-1:0], g_stage[k-1].res_q};
        end

        // Ripple slice for this chunk.
        assign chunk_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                         + (CHUNK+1)'(c_in);

        // Valid, carry and accumulated result; data loads only with a valid slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (adv[k]) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= chunk_sum[CHUNK];
                    res_q <= res_d;
                end
            end
        end

        assign stage_v[k] = v_q;

        if (k < STAGES - 1) begin : g_tail
            logic [IN_W-CHUNK-1:0] a_hi_q;
            logic [IN_W-CHUNK-1:0] b_hi_q;

            // Operand chunks not yet consumed move down with the transaction.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (adv[k] && v_in) begin
                    a_hi_q <= a_in[IN_W-1:CHUNK];
                    b_hi_q <= b_in[IN_W-1:CHUNK];
                end
            end
        end else begin : g_last
            logic msb_cin;
            logic ovf_q;

            // Carry into the MSB recovered from the MSB sum bit.
            assign msb_cin = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ chunk_sum[CHUNK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv[k] && v_in) begin
                    ovf_q <= msb_cin ^ chunk_sum[CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].res_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised N-bit adder/subtractor built from CHUNK-bit ripple-carry slices, one slice per pipeline stage. The carry is registered between slices. Operand and result skew registers keep each transaction aligned.
It accepts one transaction per cycle through a valid/ready handshake with full backpressure. It is the datapath adder for wider-than-4-bit arithmetic in the design, and adds subtract mode and a signed-overflow flag.

Parameters:
WIDTH, 16, operand and result width in bits; must be a positive multiple of CHUNK.
CHUNK, 4, bits per ripple slice and per pipeline stage.
STAGES, WIDTH/CHUNK, derived localparam, not overridable; equals pipeline depth and latency.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a transaction
in_ready  output  1  block accepts the transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
out_valid  output  1  result presented
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB; in subtract mode 1 means no borrow
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, out_valid, sum, cout and ovf clear to 0.
  - Any in-flight transactions are discarded.
  - in_ready is 1 from the first edge after reset is released.
- Accept and transfer:
  - A transaction is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff, using c0 (k=0) or the registered carry from stage k-1.
  - Registers the chunk sum, the carry out and the still-unconsumed upper operand chunks.
  - Lower result chunks are carried forward in skew registers.
  - The last stage also registers ovf, computed from the MSB carry-in and carry-out.
- Latency and throughput:
  - Accept at edge T produces out_valid with the complete result after edge T+STAGES-1, with no stall.
  - STAGES=1 gives a single registered adder whose result is visible one cycle after acceptance.
  - Sustained throughput is 1 transaction per cycle while out_ready=1.
- Flow control:
  - Stage k advances when its valid bit is 0, or stage k+1 advances. For the last stage, stage k+1 advancing means out_ready.
  - in_ready = stage 0 may advance; it is combinational from out_ready through the stage valid chain.
  - A bubble in any stage is squeezed out while downstream is stalled.
  - Up to STAGES transactions are held; with every stage valid and out_ready=0, in_ready=0.
- Output stability:
  - While out_valid && !out_ready, sum, cout and ovf hold stable.
  - Each result is delivered exactly once, in acceptance order.
- Simultaneous events:
  - An accept and a result transfer in the same cycle are legal with the pipeline full. The last stage drains and everything shifts, so in_ready=1 in that cycle.
- No-accept cycles:
  - Input data is ignored when in_valid=0 or in_ready=0; no state changes.
- Width rule:
  - WIDTH not a multiple of CHUNK is a configuration error, flagged by an elaboration-time check.

Test Plan:
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> out_valid high 4 cycles after accept with sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- sub=1, cin=1 (ignored): a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Stream 10 random back-to-back transactions; hold out_ready=0 for 6 cycles mid-stream -> in_ready falls after 4 outstanding. Outputs hold stable while stalled. All 10 results match the model, in order, with no duplicates.
- Full pipeline with out_ready=1 and in_valid=1 in the same cycle -> one result out, one accepted, in_ready=1. Inject bubbles (in_valid toggling) -> out_valid pattern mirrors the input pattern delayed by 4 cycles.
- Assert rst_n low with 3 transactions in flight -> out_valid=0 immediately, with no reset-release edge needed. After release, the next accepted transaction is the first result, 4 cycles later.
- Repeat the add and subtract cases with CHUNK=16 (STAGES=1, latency 1) and WIDTH=32, CHUNK=8 -> results match the model.
